mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for MIPS mult/multu/div/divu, plus the mthi/mtlo writes.
//  Sits in the execute stage beside the ALU and takes the same register-file operands (in_a = rs, in_b = rt).
//  The HI/LO outputs feed the mfhi/mflo writeback mux.
//  While busy is high, control stalls any instruction that touches HI/LO.
// PARAMETERS
//  DATA_W  32  operand/HI/LO width; iterative latency = DATA_W + 2 cycles (start to done)
// PORTS
//  clk          in   1       single clock; all state changes on rising edge
//  rst_n        in   1       reset, asynchronous assert, active-low
//  start        in   1       launch operation; sampled only in IDLE
//  op           in   2       00 mult, 01 multu, 10 div, 11 divu
//  in_a         in   DATA_W  multiplicand / dividend (rs)
//  in_b         in   DATA_W  multiplier / divisor (rt)
//  hi_we        in   1       mthi: hi <= wr_data
//  lo_we        in   1       mtlo: lo <= wr_data
//  wr_data      in   DATA_W  data for mthi/mtlo
//  busy         out  1       operation in progress
//  done         out  1       one-cycle pulse; hi/lo valid
//  div_by_zero  out  1       pulses with done when a div/divu had in_b == 0
//  hi           out  DATA_W  HI register (product upper half / remainder)
//  lo           out  DATA_W  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-operation):
//   - state <= IDLE; hi = lo = 0; busy = done = div_by_zero = 0.
//   - No done is produced for the aborted operation.
//  FSM states: IDLE -> CALC (DATA_W cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE, start=1 (sampled edge N):
//   - Latch op, operand magnitudes and sign bits; clear the iteration counter; go to CALC.
//   - Signed ops take two's-complement magnitudes. Unsigned ops use operands as-is.
//  CALC, one bit per cycle:
//   - Multiply: shift-add over the 2*DATA_W accumulator.
//   - Divide: restoring shift-subtract, giving quotient and remainder.
//   - After DATA_W cycles, go to FIX.
//  FIX (signed ops only):
//   - Negate the product if the operand signs differ.
//   - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
//   - Write hi/lo on the edge leaving FIX.
//  Timing: busy = 1 in cycles N+1..N+DATA_W+1. done = 1 only in cycle N+DATA_W+2; busy = 0 in that cycle.
//  Back-to-back: start may be asserted in the done cycle (state is IDLE).
//  Results:
//   - Multiply: {hi,lo} = full 2*DATA_W product.
//   - Divide: lo = quotient, hi = remainder.
//  Divide by zero (in_b == 0):
//   - Full latency still applies.
//   - lo = all ones; hi = in_a as latched; div_by_zero pulses with done.
//  Signed overflow (div 0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. No flag.
//  start while busy: ignored; operands are not re-latched.
//  hi_we / lo_we:
//   - Honoured only when busy = 0; ignored while busy.
//   - In the same IDLE cycle as start, the write takes effect and is later overwritten by the result.
//  hi_we and lo_we may be asserted together; both registers take wr_data.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined:
//   - mult/multu compute the product with a single-cycle multiplier and skip CALC (IDLE -> FIX).
//   - busy = 1 only in N+1; done in N+2.
//   - div/divu are unchanged.
//  MULDIV_FAST_MULT_EN undefined: all ops iterative, latency DATA_W+2.
// TESTING (DATA_W=32, macro undefined unless stated; start at edge N)
//  1 mult 23 x 40 -> done at N+34: hi=0x00000000, lo=0x00000398. busy high N+1..N+33.
//  2 mult 0xFFFFFFFD x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    multu same operands -> hi=0x00000006, lo=0xFFFFFFEB.
//  3 div 42/23 -> lo=1, hi=19.
//    div 0xFFFFFFD6(-42)/23 -> lo=0xFFFFFFFF, hi=0xFFFFFFED.
//    div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 divu 42/0 -> done at N+34: lo=0xFFFFFFFF, hi=0x0000002A, div_by_zero=1 for one cycle.
//  5 Stimulus while busy: start=1 and hi_we=1 (wr_data=0x55) at N+5 -> both ignored, first result intact.
//    Reset: rst_n=0 at N+10 -> hi=lo=0, busy=0 immediately, no done.
//  6 MULDIV_FAST_MULT_EN defined: mult 23 x 40 -> done at N+2, lo=0x398.
//    div 42/23 -> still done at N+34.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for MIPS mult/multu/div/divu, with mthi/mtlo writes.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier on mult/multu (IDLE -> FIX).
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // state | meaning
    // IDLE  | waiting for start; mthi/mtlo accepted
    // CALC  | one product/quotient bit per cycle, DATA_W cycles
    // FIX   | sign correction; hi/lo written on exit
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic              sign_a, sign_b;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W-1:0] acc_hi, acc_lo;
    logic [CW-1:0]     cnt;

    logic                in_signed;
    logic [DATA_W-1:0]   in_mag_a, in_mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic                q_signed, signs_differ, b_zero;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*DATA_W-1:0] fast_prod;
`endif

    always_comb begin
        in_signed    = ~op[0];
        in_mag_a     = (in_signed && in_a[DATA_W-1]) ? -in_a : in_a;
        in_mag_b     = (in_signed && in_b[DATA_W-1]) ? -in_b : in_b;
        mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        div_shift    = {acc_hi, acc_lo[DATA_W-1]};
        div_ge       = (div_shift >= {1'b0, mag_b});
        q_signed     = ~op_q[0];
        signs_differ = q_signed && (sign_a ^ sign_b);
        b_zero       = (mag_b == '0);
        prod_fix     = signs_differ ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        // divide-by-zero quotient is all ones regardless of the dividend's sign
        quo_fix      = b_zero ? '1 : (signs_differ ? -acc_lo : acc_lo);
        rem_fix      = (q_signed && sign_a) ? -acc_hi : acc_hi;
`ifdef MULDIV_FAST_MULT_EN
        fast_prod    = {{DATA_W{1'b0}}, in_mag_a} * {{DATA_W{1'b0}}, in_mag_b};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wr_data;
                    if (lo_we) lo <= wr_data;
                    if (start) begin
                        op_q   <= op;
                        sign_a <= in_signed & in_a[DATA_W-1];
                        sign_b <= in_signed & in_b[DATA_W-1];
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? in_mag_a : in_mag_b;
                        cnt    <= CW'(DATA_W - 1);
                        busy   <= 1'b1;
                        state  <= CALC;
`ifdef MULDIV_FAST_MULT_EN
                        if (!op[1]) begin
                            {acc_hi, acc_lo} <= fast_prod;
                            state            <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (!op_q[1]) begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
                    end else if (div_ge) begin
                        acc_hi <= div_shift[DATA_W-1:0] - mag_b;
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (!op_q[1]) begin
                        {hi, lo} <= prod_fix;
                    end else begin
                        hi          <= rem_fix;
                        lo          <= quo_fix;
                        div_by_zero <= b_zero;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes reference results, negedge monitor pops on done.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk, rst_n, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] in_a, in_b, wr_data;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .in_a(in_a), .in_b(in_b), .hi_we(hi_we), .lo_we(lo_we),
        .wr_data(wr_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0, passes = 0;
    int           busy_from = 0, busy_to = -1;
    int           done_seen = 0;
    int           last_due = 0;
    logic [W-1:0] model_hi = '0, model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // returns {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sbv;
        logic [2*W:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = '0;
        case (o)
            2'b00: r = {1'b0, 64'(sa * sbv)};
            2'b01: r = {1'b0, {32'b0, a} * {32'b0, b}};
            2'b10: if (b == '0) r = {1'b1, a, {W{1'b1}}};
                   else r = {1'b0, W'(sa % sbv), W'(sa / sbv)};
            default: if (b == '0) r = {1'b1, a, {W{1'b1}}};
                     else r = {1'b0, a % b, a / b};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = W'($urandom_range(0, 255));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // called just after a rising edge; start is sampled on the next edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W:0] r;
        exp_t         e;
        int           lat;
        r     = ref_op(o, a, b);
        lat   = (FAST && !o[1]) ? 2 : W + 2;
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        e.hi  = r[2*W-1:W];
        e.lo  = r[W-1:0];
        e.dbz = r[2*W];
        e.due = cyc + lat;
        busy_from = cyc + 1;
        busy_to   = e.due - 1;
        last_due  = e.due;
        exp_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        in_a  = $urandom;
        in_b  = $urandom;
    endtask

    task automatic wait_done();
        while (cyc < last_due) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reg_write(input logic h, input logic l, input logic [W-1:0] d);
        hi_we = h; lo_we = l; wr_data = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
        chk("reg_write_hi", hi, model_hi);
        chk("reg_write_lo", lo, model_lo);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                chk("done_missing", 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
            chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", cyc, mon_e.due);
                    chk("result_hi", hi, mon_e.hi);
                    chk("result_lo", lo, mon_e.lo);
                    chk("div_by_zero", div_by_zero, mon_e.dbz);
                end
            end else begin
                chk("dbz_without_done", div_by_zero, 1'b0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds;
        rst_n = 1'b0; start = 1'b0; op = '0; in_a = '0; in_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, 32'd23, 32'd40);               wait_done();
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_done();
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);         wait_done();
        issue(2'b10, 32'd42, 32'd23);               wait_done();
        issue(2'b10, 32'hFFFF_FFD6, 32'd23);        wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(2'b11, 32'd42, 32'd0);                wait_done();
        issue(2'b10, 32'hFFFF_FFD6, 32'd0);         wait_done();
        @(posedge clk); #1;

        reg_write(1'b1, 1'b1, 32'h1234_5678);
        reg_write(1'b1, 1'b0, 32'hCAFE_0001);
        reg_write(1'b0, 1'b1, 32'h0BAD_F00D);

        // mthi in the same cycle as start lands, then the product overwrites it
        hi_we = 1'b1; wr_data = 32'h0000_ABCD;
        issue(2'b01, 32'd5, 32'd6);
        hi_we = 1'b0;
        chk("mthi_with_start", hi, 32'h0000_ABCD);
        wait_done();
        @(posedge clk); #1;

        // start and mthi while busy are both ignored
        reg_write(1'b1, 1'b0, 32'h0000_0077);
        issue(2'b00, 32'd23, 32'd40);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b10; in_a = 32'd1; in_b = 32'd1; hi_we = 1'b1; wr_data = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        chk("mthi_while_busy", hi, 32'h0000_0077);
        wait_done();
        @(posedge clk); #1;

        // reset mid-operation: registers clear at once and no done follows
        issue(2'b11, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midop_reset_hi", hi, 0);
        chk("midop_reset_lo", lo, 0);
        chk("midop_reset_busy", busy, 0);
        exp_q.delete();
        busy_to  = -1;
        model_hi = '0;
        model_lo = '0;
        ds = done_seen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("no_done_after_reset", done_seen, ds);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 4) == 0)
                reg_write(1'($urandom), 1'($urandom), $urandom);
            issue(2'($urandom), pick(), pick());
            wait_done();
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
